ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 33 +++
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and constants for the two-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2
   } arb_state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // On a tie the port that did not win last time is chosen.
   function automatic logic rr_pick(input logic a_pend, input logic b_pend,
                                    input logic last_grant);
      if (a_pend && b_pend)
         return (last_grant == PORT_A) ? PORT_B : PORT_A;
      else
         return b_pend ? PORT_B : PORT_A;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin arbiter sharing one registered-output RAM between an
//            instruction-fetch read port (A) and a data read/write port (B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   logic       r_gnt_port;
   logic       r_last_grant;
   logic       r_is_write;
   logic       w_a_pend;
   logic       w_b_pend;
   logic       w_grant;
   logic       w_grant_port;

   // A port whose ack is showing this cycle has already been served.
   assign w_a_pend = a_req && !a_ack;
   assign w_b_pend = b_req && !b_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_grant_port = PORT_A;
      case (r_state)
         ST_IDLE: begin
            if (w_a_pend || w_b_pend) begin
               w_grant      = 1'b1;
               w_grant_port = rr_pick(w_a_pend, w_b_pend, r_last_grant);
               w_state_nxt  = ST_ACCESS;
            end
         end
         ST_ACCESS:  w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt_port   <= PORT_A;
         r_last_grant <= PORT_B;
         r_is_write   <= 1'b0;
         ram_addr     <= '0;
         ram_din      <= '0;
         a_ack        <= 1'b0;
         b_ack        <= 1'b0;
         a_rdata      <= '0;
         b_rdata      <= '0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         if (w_grant) begin
            r_gnt_port   <= w_grant_port;
            r_last_grant <= w_grant_port;
            if (w_grant_port == PORT_B) begin
               ram_addr   <= b_addr;
               r_is_write <= b_we;
               if (b_we)
                  ram_din <= b_wdata;
            end else begin
               ram_addr   <= a_addr;
               r_is_write <= 1'b0;
            end
         end
         // RAM output for the address presented in ACCESS is valid now.
         if (r_state == ST_CAPTURE) begin
            if (r_gnt_port == PORT_A) begin
               a_ack   <= 1'b1;
               a_rdata <= ram_dout;
            end else begin
               b_ack <= 1'b1;
               if (!r_is_write)
                  b_rdata <= ram_dout;
            end
         end
      end
   end

   // Decoded from state so an asynchronous reset drops it immediately.
   assign ram_wea = (r_state == ST_ACCESS) && r_is_write;
   assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a behavioural
//            registered-output RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          a_req;
   logic [AW-1:0] a_addr;
   logic          a_ack;
   logic [DW-1:0] a_rdata;
   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_ack;
   logic [DW-1:0] b_rdata;
   logic          ram_wea;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int wea_edges = 0;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_ack    (a_ack),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_ack    (b_ack),
      .b_rdata  (b_rdata),
      .ram_wea  (ram_wea),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   always_ff @(posedge clk) begin
      if (ram_wea)
         mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always_ff @(posedge clk)
      if (ram_wea === 1'b1)
         wea_edges <= wea_edges + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the cycle the selected ack is seen, or after the limit.
   task automatic wait_ack(input logic port_b, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (((port_b ? b_ack : a_ack) !== 1'b1) && (n < limit));
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_wea"},     ram_wea,  0);
      chk({pfx, "_addr"},    ram_addr, 0);
      chk({pfx, "_din"},     ram_din,  0);
      chk({pfx, "_a_ack"},   a_ack,    0);
      chk({pfx, "_b_ack"},   b_ack,    0);
      chk({pfx, "_a_rdata"}, a_rdata,  0);
      chk({pfx, "_b_rdata"}, b_rdata,  0);
      chk({pfx, "_busy"},    busy,     0);
   endtask

   task automatic b_xact(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int n);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      wait_ack(1'b1, 10, n);
   endtask

   task automatic release_idle();
      a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      int w0;
      int nacks;
      int last;
      rst = 1'b1;
      a_req = 1'b0; a_addr = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;

      // B write 0x12 <- 0xBEEF, cycle by cycle
      w0 = wea_edges;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h12; b_wdata = 16'hBEEF;
      tick();
      chk("wr_busy_access", busy, 1);
      chk("wr_wea_access", ram_wea, 1);
      chk("wr_addr", ram_addr, 32'h12);
      chk("wr_din", ram_din, 32'hBEEF);
      tick();
      chk("wr_wea_capture", ram_wea, 0);
      chk("wr_no_early_ack", b_ack, 0);
      tick();
      chk("wr_ack", b_ack, 1);
      chk("wr_wea_idle", ram_wea, 0);
      chk("wr_b_rdata_kept", b_rdata, 0);
      chk("wr_busy_idle", busy, 0);

      // A read issued in B's ack cycle: the other port may be granted
      b_req = 1'b0; b_we = 1'b0;
      a_req = 1'b1; a_addr = 8'h12;
      wait_ack(1'b0, 10, n);
      chk("rd_a_latency", n, 3);
      chk("rd_a_ack", a_ack, 1);
      chk("rd_a_rdata", a_rdata, 32'hBEEF);
      chk("rd_a_addr", ram_addr, 32'h12);
      chk("rd_b_ack_clear", b_ack, 0);
      chk("wea_one_cycle", wea_edges - w0, 1);
      release_idle();

      // Preload, then B read followed by B write
      b_xact(1'b1, 8'h00, 16'h0F0F, n);
      release_idle();
      b_xact(1'b1, 8'h05, 16'h00AA, n);
      release_idle();
      b_xact(1'b0, 8'h05, 16'h0000, n);
      chk("brd_latency", n, 3);
      chk("brd_rdata", b_rdata, 32'h00AA);
      release_idle();
      b_xact(1'b1, 8'h06, 16'h1234, n);
      chk("bwr_ack", b_ack, 1);
      chk("bwr_rdata_kept", b_rdata, 32'h00AA);
      release_idle();

      // Simultaneous requests straight after reset: A wins the first tie
      #2 rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_a_rdata", a_rdata, 0);
      a_req = 1'b1; a_addr = 8'h05;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h06;
      wait_ack(1'b0, 10, n);
      chk("tie_a_first_lat", n, 3);
      chk("tie_a_ack", a_ack, 1);
      chk("tie_b_not_yet", b_ack, 0);
      chk("tie_a_rdata", a_rdata, 32'h00AA);
      a_req = 1'b0;
      wait_ack(1'b1, 10, n);
      chk("tie_b_gap", n, 3);
      chk("tie_b_rdata", b_rdata, 32'h1234);
      chk("tie_a_quiet", a_ack, 0);
      release_idle();

      // Continuous requests from both ports: grants alternate A,B,...
      a_req = 1'b1; a_addr = 8'h05;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h06;
      nacks = 0;
      last = 0;
      for (int c = 1; c <= 40 && nacks < 6; c++) begin
         tick();
         if (a_ack || b_ack) begin
            chk("rr_no_overlap", a_ack & b_ack, 0);
            chk("rr_order_is_b", b_ack, nacks % 2);
            chk("rr_gap", c - last, 3);
            if (a_ack)
               chk("rr_a_rdata", a_rdata, 32'h00AA);
            else
               chk("rr_b_rdata", b_rdata, 32'h1234);
            last = c;
            nacks++;
         end
      end
      chk("rr_count", nacks, 6);
      release_idle();

      // A requester holds a_req through its ack cycle
      a_req = 1'b1; a_addr = 8'h05;
      wait_ack(1'b0, 10, n);
      chk("hold_latency", n, 3);
      tick();
      chk("hold_no_regrant", busy, 0);
      a_req = 1'b0;
      tick();
      chk("hold_still_idle", busy, 0);
      tick();
      tick();
      chk("hold_no_ack", a_ack, 0);

      // Reset in the ACCESS cycle of a B write aborts it
      w0 = wea_edges;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 16'h5555;
      tick();
      chk("abort_wea_before", ram_wea, 1);
      #2 rst = 1'b1;
      #1;
      check_zero("abort");
      b_req = 1'b0; b_we = 1'b0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("abort_no_b_ack", b_ack, 0);
      end
      chk("abort_no_write", wea_edges - w0, 0);
      a_req = 1'b1; a_addr = 8'h00;
      wait_ack(1'b0, 10, n);
      chk("post_rst_latency", n, 3);
      chk("post_rst_a_ack", a_ack, 1);
      chk("post_rst_a_rdata", a_rdata, 32'h0F0F);
      chk("post_rst_addr", ram_addr, 0);
      release_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
